uart_frame_sched: RTL and testbench
===================================

# uart_frame_sched

Round-robin frame scheduler that shares one RS-485 UART serializer among `NSRC` frame sources. It grants one requesting source at a time and raises the serializer's request line. While the frame is sent, it routes the granted source's byte to the serializer by the address the serializer presents. It detects frame completion or a stalled serializer, then enforces an inter-frame gap before the next grant.

## Interface
- `NSRC`, 4: number of frame sources, 2..8.
- `GAP_CYC`, 16: idle cycles with `ser_rq` low between frames, 1..255.
- `TIMEOUT`, 255: max cycles waiting for `ser_busy` to rise after `ser_rq`, 1..255.

- `clk`  in  1  system clock; serializer runs on the same clock.
- `reset`  in  1  asynchronous, active-high reset.
- `src_req`  in  NSRC  level request per source; bit i = source i has a frame ready.
- `src_data`  in  8*NSRC  byte from each source; source i at [8i+7:8i], addressed by `src_addr`.
- `src_addr`  out  5  byte address to sources; equals `ser_addr`.
- `src_grant`  out  NSRC  one-hot grant; zero when no frame is in progress.
- `src_done`  out  NSRC  one-cycle pulse on bit i when source i's frame completes.
- `src_err`  out  NSRC  one-cycle pulse on bit i when source i's frame times out.
- `ser_rq`  out  1  request to serializer; held high for the whole frame.
- `ser_addr`  in  5  byte index from serializer.
- `ser_data`  out  8  granted source's byte; 8'h00 when `src_grant` is 0.
- `ser_busy`  in  1  serializer line-driver enable; high from before the start bit until after the last stop bit.
- `cycle`  out  5  completed-frame sequence counter.

## Operation
- States: IDLE, ARB, REQ, BUSY, GAP.
- Reset values: state IDLE, `src_grant`=0, `src_done`=0, `src_err`=0, `ser_rq`=0, `cycle`=0, rr pointer=0, counters=0. Reset is asynchronous and takes effect immediately, including mid-frame.
- IDLE: if `src_req`≠0, go to ARB.
- ARB: search from the pointer upward, modulo NSRC. Register `src_grant` = one-hot of the first set `src_req` bit. If none is set (request withdrawn), return to IDLE. Otherwise go to REQ with wait counter=0.
- REQ: `ser_rq`=1.
  - If `ser_busy`=1, go to BUSY.
  - Else increment the wait counter. When the counter reaches TIMEOUT: pulse `src_err[g]`, clear grant, pointer=g+1 mod NSRC, go to GAP. `cycle` is unchanged.
- BUSY: `ser_rq`=1. On `ser_busy`=0:
  - pulse `src_done[g]`;
  - `cycle` = `cycle`+1, wrapping 31→0;
  - pointer = g+1 mod NSRC;
  - clear grant;
  - go to GAP.
- GAP: `ser_rq`=0. Count GAP_CYC cycles, then go to IDLE.
- Once ARB has granted, `src_req` is ignored until GAP. Deasserting the granted request mid-frame does not abort the frame.
- `ser_data` and `src_addr` are combinational from `src_grant`, `src_data` and `ser_addr`.
- Only one bit of `src_done`/`src_err` is ever high, and never both in the same cycle.

## Timing
- `src_req` rising in IDLE at cycle 0: ARB at cycle 1; `src_grant` and `ser_rq` high from cycle 2.
- `ser_busy` high sampled at edge k: BUSY from k+1.
- `ser_busy` low sampled at edge m: at m+1, `ser_rq`=0, grant=0, `src_done` pulses for exactly one cycle, `cycle` updated.
- Gap: `ser_rq` stays low for exactly GAP_CYC+2 cycles minimum (GAP_CYC in GAP, plus IDLE and ARB) before the next frame's `ser_rq` rises. This guarantees the serializer sees RQ low and re-arms.
- Timeout: the `src_err` pulse occurs TIMEOUT+1 cycles after `ser_rq` rises.
- Fairness: with all sources requesting continuously, grants cycle 0,1,…,NSRC-1,0,… and no source waits more than NSRC-1 frames.

## Test plan
- Single source: `src_req`=4'b0100, serializer model asserts busy 10 cycles after rq for 200 cycles. Required: `src_grant`=4'b0100, `ser_data` follows `src_data[23:16]` for each `ser_addr`, one `src_done`=4'b0100 pulse, `cycle`=1, `ser_rq` low ≥ GAP_CYC+2 cycles afterwards.
- Round robin: `src_req`=4'b1111 held for 8 frames. Required: grant order 0,1,2,3,0,1,2,3; `cycle`=8.
- Timeout: `src_req`=4'b0010, busy never rises. Required: `src_err`=4'b0010 exactly TIMEOUT+1 cycles after `ser_rq` rises; `cycle` unchanged; the next grant goes to source 1 again only after GAP.
- Wrap: 33 completed frames. Required: `cycle` reads 0 after the 32nd frame and 1 after the 33rd.
- Reset mid-frame: assert `reset` in BUSY. Required: `ser_rq`, `src_grant`, `cycle` and the pointer are 0 in the same cycle; after release with `src_req`=4'b0001, grant goes to source 0.
- Withdrawal: a request pulses for one cycle in IDLE, then drops before ARB. Required: return to IDLE, no grant, `ser_rq` never asserts.

Source files
------------

// File: rtl/uart_frame_sched.sv
// uart_frame_sched
// Round-robin scheduler that shares one RS-485 UART serializer among NSRC
// frame sources. It grants one requesting source at a time, holds ser_rq high
// for the whole frame and routes the granted source's byte to the serializer.
// When the frame completes or the serializer stalls, it enforces an
// inter-frame gap before the next grant.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   src_req          level request per source (bit i = source i has a frame)
//   src_data         byte from each source, source i at [8i+7:8i]
//   src_addr         byte address to the sources (mirrors ser_addr)
//   src_grant        one-hot grant, zero when no frame is in progress
//   src_done         one-cycle pulse on the granted bit at frame completion
//   src_err          one-cycle pulse on the granted bit on serializer timeout
//   ser_rq           request to the serializer, high for the whole frame
//   ser_addr         byte index presented by the serializer
//   ser_data         granted source's byte, 8'h00 when nothing is granted
//   ser_busy         serializer line-driver enable
//   cycle            completed-frame sequence counter (wraps 31 -> 0)
//   fsm_state        current scheduler state, for observation only
//
// Handshake: ser_rq rises one cycle after arbitration and stays high until
// the frame ends. The serializer acknowledges by raising ser_busy; the frame
// is complete on the first sampled ser_busy low after that. If ser_busy never
// rises, the frame is abandoned TIMEOUT+1 cycles after ser_rq rose.
module uart_frame_sched #(
  parameter int NSRC    = 4,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src_req,
  input  logic [8*NSRC-1:0] src_data,
  output logic [4:0]        src_addr,
  output logic [NSRC-1:0]   src_grant,
  output logic [NSRC-1:0]   src_done,
  output logic [NSRC-1:0]   src_err,
  output logic              ser_rq,
  input  logic [4:0]        ser_addr,
  output logic [7:0]        ser_data,
  input  logic              ser_busy,
  output logic [4:0]        cycle,
  output logic [2:0]        fsm_state
);

  localparam int IW = $clog2(NSRC);
  // One extra bit so pointer+offset never overflows before the wrap.
  localparam int SW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_REQ  = 3'd2,
    S_BUSY = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [7:0]      wait_cnt;
  logic [7:0]      gap_cnt;

  logic            found;
  logic [IW-1:0]   pick;
  logic [NSRC-1:0] pick_oh;
  logic [SW-1:0]   sum;
  logic [SW-1:0]   nxt_sum;
  logic [IW-1:0]   nxt_ptr;

  // Round-robin search: scan offsets from the far end down so the nearest
  // requester at or above the pointer is the last one written and wins.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    sum     = '0;
    pick_oh = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NSRC)) sum = sum - SW'(NSRC);
      if (src_req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
    pick_oh[pick] = 1'b1;
  end

  // Pointer moves to the source after the one just served.
  always_comb begin
    nxt_sum = {1'b0, gidx} + SW'(1);
    nxt_ptr = (nxt_sum == SW'(NSRC)) ? '0 : nxt_sum[IW-1:0];
  end

  // Byte routing is purely a function of the registered grant.
  always_comb begin
    ser_data = 8'h00;
    for (int i = 0; i < NSRC; i++) begin
      if (src_grant[i]) ser_data = ser_data | src_data[8*i +: 8];
    end
  end

  assign src_addr  = ser_addr;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      src_grant <= '0;
      src_done  <= '0;
      src_err   <= '0;
      ser_rq    <= 1'b0;
      cycle     <= '0;
      ptr       <= '0;
      gidx      <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      src_done <= '0;
      src_err  <= '0;
      case (state)
        S_IDLE: begin
          if (|src_req) state <= S_ARB;
        end
        S_ARB: begin
          if (found) begin
            src_grant <= pick_oh;
            gidx      <= pick;
            ser_rq    <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ser_busy) begin
            state <= S_BUSY;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            src_err   <= src_grant;
            src_grant <= '0;
            ser_rq    <= 1'b0;
            ptr       <= nxt_ptr;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_BUSY: begin
          if (!ser_busy) begin
            src_done  <= src_grant;
            cycle     <= cycle + 5'd1;
            ptr       <= nxt_ptr;
            src_grant <= '0;
            ser_rq    <= 1'b0;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'(GAP_CYC - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Testbench for uart_frame_sched: a timeline model of the scheduler written
// as straight-line frame procedures, a serializer model that answers ser_rq,
// a per-cycle compare process, a monitor that logs grants/pulses/gaps, and
// scenario-level literal checks.
module tb_uart_frame_sched;

  localparam int NSRC    = 4;
  localparam int GAP_CYC = 16;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   src_req;
  logic [8*NSRC-1:0] src_data;
  logic [4:0]        src_addr;
  logic [NSRC-1:0]   src_grant;
  logic [NSRC-1:0]   src_done;
  logic [NSRC-1:0]   src_err;
  logic              ser_rq;
  logic [4:0]        ser_addr;
  logic [7:0]        ser_data;
  logic              ser_busy;
  logic [4:0]        cycle;
  logic [2:0]        fsm_state;

  uart_frame_sched #(.NSRC(NSRC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_addr(src_addr), .src_grant(src_grant), .src_done(src_done),
    .src_err(src_err), .ser_rq(ser_rq), .ser_addr(ser_addr),
    .ser_data(ser_data), .ser_busy(ser_busy), .cycle(cycle),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit abort = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source byte tables: each source answers src_addr from its own table.
  logic [7:0] tbl [NSRC][32];
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NSRC; i++) src_data[8*i +: 8] = tbl[i][src_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- serializer model (stimulus) ----------------
  bit ser_en  = 1'b1;
  int fix_dly = 0;
  int fix_len = 0;

  initial begin
    int sp, cnt, dly, len;
    sp = 0; cnt = 0; dly = 0; len = 0;
    ser_busy = 1'b0;
    ser_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        ser_busy = 1'b0;
        sp = 0;
      end else begin
        case (sp)
          0: if (ser_rq && ser_en) begin
               dly = (fix_dly != 0) ? fix_dly : int'($urandom_range(1, 12));
               len = (fix_len != 0) ? fix_len : int'($urandom_range(2, 24));
               cnt = 0;
               sp = 1;
             end
          1: if (!ser_rq) sp = 0;
             else begin
               cnt++;
               if (cnt >= dly) begin
                 ser_busy = 1'b1;
                 ser_addr = '0;
                 cnt = 0;
                 sp = 2;
               end
             end
          2: if (cnt >= len) begin
               ser_busy = 1'b0;
               sp = 3;
             end else begin
               cnt++;
               ser_addr = ser_addr + 5'd1;
             end
          default: if (!ser_rq) sp = 0;
        endcase
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle following each rising edge.
  int              m_ptr = 0;
  logic [NSRC-1:0] e_grant = '0;
  logic [NSRC-1:0] e_done = '0;
  logic [NSRC-1:0] e_err = '0;
  logic            e_rq = 1'b0;
  logic [4:0]      e_cycle = '0;

  function automatic int rr_pick(logic [NSRC-1:0] req, int p);
    for (int k = 0; k < NSRC; k++) begin
      if (req[(p + k) % NSRC]) return (p + k) % NSRC;
    end
    return -1;
  endfunction

  task automatic gap_wait();
    repeat (GAP_CYC) begin
      @(posedge clk);
      if (abort) return;
      e_done = '0;
      e_err  = '0;
    end
  endtask

  // Called on an edge where the scheduler is idle; plays out one frame.
  task automatic frame_task();
    int w, n;
    if (src_req == '0) return;
    @(posedge clk);
    if (abort) return;
    w = rr_pick(src_req, m_ptr);
    if (w < 0) return;
    e_grant = '0;
    e_grant[w] = 1'b1;
    e_rq = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      if (abort) return;
      n++;
      if (ser_busy) break;
      if (n == TIMEOUT + 1) begin
        e_err   = e_grant;
        e_grant = '0;
        e_rq    = 1'b0;
        m_ptr   = (w + 1) % NSRC;
        gap_wait();
        return;
      end
    end
    forever begin
      @(posedge clk);
      if (abort) return;
      if (!ser_busy) break;
    end
    e_done  = e_grant;
    e_grant = '0;
    e_rq    = 1'b0;
    e_cycle = e_cycle + 5'd1;
    m_ptr   = (w + 1) % NSRC;
    gap_wait();
  endtask

  initial forever begin
    @(posedge clk);
    if (abort) begin
      m_ptr = 0; e_grant = '0; e_done = '0; e_err = '0; e_rq = 1'b0; e_cycle = '0;
    end else begin
      frame_task();
    end
  end

  function automatic logic [7:0] exp_data();
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < NSRC; i++) if (e_grant[i]) d = tbl[i][ser_addr];
    return d;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!abort && !reset) begin
      chk("grant",    32'(src_grant), 32'(e_grant));
      chk("ser_rq",   32'(ser_rq),    32'(e_rq));
      chk("done",     32'(src_done),  32'(e_done));
      chk("err",      32'(src_err),   32'(e_err));
      chk("cycle",    32'(cycle),     32'(e_cycle));
      chk("ser_data", 32'(ser_data),  32'(exp_data()));
      chk("src_addr", 32'(src_addr),  32'(ser_addr));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int              grant_log[$];
  logic [NSRC-1:0] done_q[$];
  logic [NSRC-1:0] err_q[$];
  logic [2:0]      exp_q[$];
  int n_done = 0, n_err = 0, rq_hi = 0;
  int rise_cyc = 0, err_gap = 0, low_run = 0, min_gap = 1000;
  bit seen_fall = 1'b0;
  logic [NSRC-1:0] prev_grant = '0;
  logic            prev_rq = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (src_grant != '0 && prev_grant == '0)
        for (int i = 0; i < NSRC; i++) if (src_grant[i]) grant_log.push_back(i);
      if (src_done != '0) begin n_done++; done_q.push_back(src_done); end
      if (src_err != '0) begin n_err++; err_q.push_back(src_err); err_gap = cyc - rise_cyc; end
      if (ser_rq && !prev_rq) begin
        rise_cyc = cyc;
        if (seen_fall && low_run < min_gap) min_gap = low_run;
      end
      if (!ser_rq) begin
        low_run = prev_rq ? 1 : low_run + 1;
        if (prev_rq) seen_fall = 1'b1;
      end
      if (ser_rq) rq_hi++;
    end
    prev_grant = src_grant;
    prev_rq    = ser_rq;
  end

  task automatic clear_mon();
    grant_log.delete(); done_q.delete(); err_q.delete(); exp_q.delete();
    n_done = 0; n_err = 0; rq_hi = 0; low_run = 0; min_gap = 1000; seen_fall = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    abort = 1'b1;
    reset = 1'b1;
    src_req = '0;
    cycles(3);
    reset = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(int target, int budget);
    int k = 0;
    while (n_done < target && k < budget) begin cycles(1); k++; end
    chk("done_wait", 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_err(int target, int budget);
    int k = 0;
    while (n_err < target && k < budget) begin cycles(1); k++; end
    chk("err_wait", 32'(n_err >= target), 32'd1);
  endtask

  task automatic wait_grants(int target, int budget);
    int k = 0;
    while (grant_log.size() < target && k < budget) begin cycles(1); k++; end
    chk("grant_wait", 32'(grant_log.size() >= target), 32'd1);
  endtask

  function automatic int log_at(int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b1;
    src_req = '0;
    for (int i = 0; i < NSRC; i++)
      for (int a = 0; a < 32; a++) tbl[i][a] = 8'($urandom_range(0, 255));

    // Reset state
    do_reset();
    chk("rst_rq",    32'(ser_rq),    32'd0);
    chk("rst_grant", 32'(src_grant), 32'd0);
    chk("rst_cycle", 32'(cycle),     32'd0);
    chk("rst_done",  32'(src_done),  32'd0);
    chk("rst_err",   32'(src_err),   32'd0);

    // Single source; request dropped mid-frame must not abort it
    clear_mon();
    fix_dly = 10; fix_len = 200;
    src_req = 4'b0100;
    wait_grants(1, 20);
    src_req = '0;
    wait_done(1, 400);
    cycles(GAP_CYC + 10);
    chk("single_cycle", 32'(cycle), 32'd1);
    chk("single_ndone", 32'(done_q.size()), 32'd1);
    chk("single_done",  32'(done_q.size() > 0 ? done_q[0] : '0), 32'h4);
    chk("single_grant", 32'(log_at(0)), 32'd2);
    fix_dly = 0; fix_len = 0;

    // Round robin, all requesting
    do_reset();
    clear_mon();
    src_req = 4'b1111;
    wait_done(8, 3000);
    src_req = '0;
    cycles(GAP_CYC + 5);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    chk("rr_count", 32'(grant_log.size()), 32'd8);
    foreach (exp_q[i]) chk("rr_order", 32'(log_at(i)), 32'(exp_q[i]));
    chk("rr_cycle", 32'(cycle), 32'd8);
    chk("rr_gap",   32'(min_gap), 32'(GAP_CYC + 2));

    // Timeout
    do_reset();
    clear_mon();
    ser_en = 1'b0;
    src_req = 4'b0010;
    wait_err(1, TIMEOUT + 50);
    chk("to_err",   32'(err_q.size() > 0 ? err_q[0] : '0), 32'h2);
    chk("to_delay", 32'(err_gap), 32'(TIMEOUT + 1));
    chk("to_cycle", 32'(cycle), 32'd0);
    wait_grants(2, GAP_CYC + 10);
    chk("to_regrant", 32'(log_at(1)), 32'd1);
    chk("to_gap", 32'(min_gap >= GAP_CYC + 2), 32'd1);
    src_req = '0;
    ser_en = 1'b1;

    // Cycle counter wrap
    do_reset();
    clear_mon();
    fix_dly = 1; fix_len = 3;
    src_req = 4'($urandom_range(1, 15));
    wait_done(32, 5000);
    chk("wrap32", 32'(cycle), 32'd0);
    wait_done(33, 300);
    chk("wrap33", 32'(cycle), 32'd1);
    src_req = '0;
    fix_dly = 0; fix_len = 0;

    // Randomized traffic
    do_reset();
    clear_mon();
    for (int it = 0; it < 120; it++) begin
      src_req = 4'($urandom_range(0, 15));
      cycles(int'($urandom_range(1, 60)));
    end
    src_req = '0;
    cycles(300);

    // Reset mid-frame with pointer away from 0
    do_reset();
    clear_mon();
    src_req = 4'b0001;
    wait_done(1, 300);
    src_req = 4'b0010;
    begin
      int k = 0;
      while (!(ser_busy && src_grant == 4'b0010) && k < 300) begin cycles(1); k++; end
      chk("mid_busy_wait", 32'(k < 300), 32'd1);
    end
    #2;
    abort = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rq",    32'(ser_rq),    32'd0);
    chk("mid_grant", 32'(src_grant), 32'd0);
    chk("mid_cycle", 32'(cycle),     32'd0);
    cycles(3);
    reset = 1'b0;
    abort = 1'b0;
    clear_mon();
    src_req = 4'b1111;
    wait_grants(1, 20);
    chk("mid_ptr", 32'(log_at(0)), 32'd0);
    src_req = '0;
    cycles(200);

    // Withdrawal before arbitration
    do_reset();
    clear_mon();
    src_req = 4'b0100;
    cycles(1);
    src_req = '0;
    cycles(40);
    chk("wd_rq",    32'(rq_hi), 32'd0);
    chk("wd_grant", 32'(grant_log.size()), 32'd0);
    chk("wd_done",  32'(n_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
